// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage:
// access size encoding, FSM states, lane masks and PC-select codes.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_HALF  = 2'b01,
    SIZE_WORD  = 2'b10,
    SIZE_DWORD = 2'b11
  } mem_size_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  localparam int LANE_W = 8;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;

  localparam logic [7:0] BE_BYTE = 8'h01;
  localparam logic [7:0] BE_HALF = 8'h03;
  localparam logic [7:0] BE_WORD = 8'h0F;

  localparam logic [63:0] EXT_MASK_BYTE = 64'h0000_0000_0000_00FF;
  localparam logic [63:0] EXT_MASK_HALF = 64'h0000_0000_0000_FFFF;
  localparam logic [63:0] EXT_MASK_WORD = 64'h0000_0000_FFFF_FFFF;

  // A dword request on a 32-bit datapath degrades to a word access.
  function automatic mem_size_t eff_size(input mem_size_t s, input int data_w);
    return ((s == SIZE_DWORD) && (data_w != 64)) ? SIZE_WORD : s;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bundle between the M stage (master) and
// the memory (slave).
interface mem_access_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_W-1:0]     dmem_addr;
  logic [DATA_W/8-1:0]   dmem_be;
  logic [DATA_W-1:0]     dmem_wdata;
  logic                  dmem_ack;
  logic [DATA_W-1:0]     dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage_align.sv
// Combinational lane logic: aligned offset, byte enables, store-data
// replication and load-data lane extract with sign/zero extension.
module load_store_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB    = DATA_W / 8,
  localparam int LB    = $clog2(NB)
) (
  input  mem_size_t          size_i,
  input  logic               unsigned_i,
  input  logic [LB-1:0]      offset_i,
  input  logic [DATA_W-1:0]  store_data_i,
  input  logic [DATA_W-1:0]  load_data_i,
  output logic [LB-1:0]      aligned_offset_o,
  output logic [NB-1:0]      be_o,
  output logic [DATA_W-1:0]  store_data_o,
  output logic [DATA_W-1:0]  load_data_o
);

  mem_size_t          size_eff;
  logic [LB-1:0]      keep_mask;
  logic [NB-1:0]      be_base;
  logic [DATA_W-1:0]  ext_mask;
  logic [DATA_W-1:0]  shifted;
  logic               sign_bit;

  assign size_eff = eff_size(size_i, DATA_W);

  always_comb begin
    keep_mask = '1;
    be_base   = BE_BYTE[NB-1:0];
    ext_mask  = EXT_MASK_BYTE[DATA_W-1:0];
    case (size_eff)
      SIZE_HALF: begin
        keep_mask = ~LB'(1);
        be_base   = BE_HALF[NB-1:0];
        ext_mask  = EXT_MASK_HALF[DATA_W-1:0];
      end
      SIZE_WORD: begin
        keep_mask = ~LB'(3);
        be_base   = BE_WORD[NB-1:0];
        ext_mask  = EXT_MASK_WORD[DATA_W-1:0];
      end
      SIZE_DWORD: begin
        keep_mask = '0;
        be_base   = '1;
        ext_mask  = '1;
      end
      default: ;
    endcase
  end

  assign aligned_offset_o = offset_i & keep_mask;
  assign be_o             = be_base << aligned_offset_o;
  assign shifted          = load_data_i >> {aligned_offset_o, 3'b000};

  always_comb begin
    sign_bit = shifted[7];
    case (size_eff)
      SIZE_HALF:  sign_bit = shifted[15];
      SIZE_WORD:  sign_bit = shifted[31];
      SIZE_DWORD: sign_bit = shifted[DATA_W-1];
      default: ;
    endcase
  end

  assign load_data_o = (shifted & ext_mask) |
                       ((sign_bit && !unsigned_i) ? ~ext_mask : '0);

  // Each lane carries the copy of the store datum that lands on it.
  genvar gi;
  for (gi = 0; gi < NB; gi++) begin : g_lane
    assign store_data_o[gi*LANE_W +: LANE_W] =
        (size_eff == SIZE_BYTE) ? store_data_i[7:0] :
        (size_eff == SIZE_HALF) ? store_data_i[(gi % 2)*LANE_W +: LANE_W] :
        (size_eff == SIZE_WORD) ? store_data_i[(gi % 4)*LANE_W +: LANE_W] :
                                  store_data_i[gi*LANE_W +: LANE_W];
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline M stage: latches E-stage controls, drives the data-memory handshake,
// stalls upstream until ack. Optional MEM_MISALIGN_TRAP_EN adds exc_misalign.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_write_e,
  input  logic               mem_to_reg_e,
  input  logic               mem_read_e,
  input  logic               mem_write_e,
  input  logic [1:0]         mem_size_e,
  input  logic               mem_unsigned_e,
  input  logic               branch_e,
  input  logic               zero_e,
  input  logic [DATA_W-1:0]  alu_out_e,
  input  logic [DATA_W-1:0]  write_data_e,
  input  logic [REG_W-1:0]   write_reg_e,
  input  logic [ADDR_W-1:0]  pc_branch_e,
  output logic               stall,
  output logic [DATA_W-1:0]  read_data_m,
  output logic [DATA_W-1:0]  alu_out_m,
  output logic [REG_W-1:0]   write_reg_m,
  output logic               reg_write_m,
  output logic               mem_to_reg_m,
  output logic [1:0]         if_pc_src,
  output logic [ADDR_W-1:0]  if_pc_branch_in,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic               exc_misalign,
`endif
  mem_access_stage_if.master dmem
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  mem_state_t         state_q, state_d;
  logic               reg_write_q, mem_to_reg_q, mem_read_q, mem_write_q;
  logic               mem_unsigned_q;
  mem_size_t          mem_size_q;
  logic [DATA_W-1:0]  alu_out_q, write_data_q;
  logic [REG_W-1:0]   write_reg_q;
  logic [1:0]         if_pc_src_q, if_pc_src_d;
  logic [ADDR_W-1:0]  if_pc_branch_q, if_pc_branch_d;

  logic [ADDR_W-1:0]  addr_raw;
  logic [LB-1:0]      aligned_offset;
  logic [NB-1:0]      lane_be;
  logic [DATA_W-1:0]  lane_wdata, lane_rdata;
  logic               access_m, access_ok;

  assign addr_raw = ADDR_W'(alu_out_q);
  assign access_m = mem_read_q | mem_write_q;

  load_store_align #(.DATA_W(DATA_W)) u_align (
    .size_i           (mem_size_q),
    .unsigned_i       (mem_unsigned_q),
    .offset_i         (addr_raw[LB-1:0]),
    .store_data_i     (write_data_q),
    .load_data_i      (dmem.dmem_rdata),
    .aligned_offset_o (aligned_offset),
    .be_o             (lane_be),
    .store_data_o     (lane_wdata),
    .load_data_o      (lane_rdata)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  // A misaligned access never reaches memory; it traps for its single M cycle.
  logic misaligned;
  assign misaligned   = (addr_raw[LB-1:0] != aligned_offset);
  assign exc_misalign = access_m & misaligned;
  assign access_ok    = access_m & ~misaligned;
  assign reg_write_m  = reg_write_q & ~exc_misalign;
`else
  assign access_ok    = access_m;
  assign reg_write_m  = reg_write_q;
`endif

  assign stall            = access_ok & ~dmem.dmem_ack;
  assign dmem.dmem_req    = access_ok;
  assign dmem.dmem_we     = access_ok & mem_write_q;
  assign dmem.dmem_be     = access_ok ? lane_be : '0;
  assign dmem.dmem_wdata  = lane_wdata;
  assign dmem.dmem_addr   = {addr_raw[ADDR_W-1:LB], aligned_offset};

  assign read_data_m     = (access_ok && mem_read_q && dmem.dmem_ack) ? lane_rdata : '0;
  assign alu_out_m       = alu_out_q;
  assign write_reg_m     = write_reg_q;
  assign mem_to_reg_m    = mem_to_reg_q;
  assign if_pc_src       = if_pc_src_q;
  assign if_pc_branch_in = if_pc_branch_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (access_ok && !dmem.dmem_ack) state_d = ST_WAIT;
      ST_WAIT: if (dmem.dmem_ack)               state_d = ST_IDLE;
      default:                                  state_d = ST_IDLE;
    endcase
  end

  // The redirect is a one-cycle pulse; a stalled cycle never re-issues it.
  always_comb begin
    if_pc_src_d    = PC_SRC_SEQ;
    if_pc_branch_d = '0;
    if (!stall && branch_e && zero_e) begin
      if_pc_src_d    = PC_SRC_BRANCH;
      if_pc_branch_d = pc_branch_e;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      reg_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_unsigned_q <= 1'b0;
      mem_size_q     <= SIZE_BYTE;
      alu_out_q      <= '0;
      write_data_q   <= '0;
      write_reg_q    <= '0;
      if_pc_src_q    <= PC_SRC_SEQ;
      if_pc_branch_q <= '0;
    end else begin
      state_q        <= state_d;
      if_pc_src_q    <= if_pc_src_d;
      if_pc_branch_q <= if_pc_branch_d;
      if (!stall) begin
        reg_write_q    <= reg_write_e;
        mem_to_reg_q   <= mem_to_reg_e;
        mem_read_q     <= mem_read_e;
        mem_write_q    <= mem_write_e;
        mem_unsigned_q <= mem_unsigned_e;
        mem_size_q     <= mem_size_t'(mem_size_e);
        alu_out_q      <= alu_out_e;
        write_data_q   <= write_data_e;
        write_reg_q    <= write_reg_e;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected memory transactions are queued
// at drive time and compared when the access completes.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int REG_W  = 5;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rw;
    logic [31:0] alu;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               reg_write_e, mem_to_reg_e, mem_read_e, mem_write_e;
  logic [1:0]         mem_size_e;
  logic               mem_unsigned_e, branch_e, zero_e;
  logic [DATA_W-1:0]  alu_out_e, write_data_e;
  logic [REG_W-1:0]   write_reg_e;
  logic [ADDR_W-1:0]  pc_branch_e;
  logic               stall;
  logic [DATA_W-1:0]  read_data_m, alu_out_m;
  logic [REG_W-1:0]   write_reg_m;
  logic               reg_write_m, mem_to_reg_m;
  logic [1:0]         if_pc_src;
  logic [ADDR_W-1:0]  if_pc_branch_in;
`ifdef MEM_MISALIGN_TRAP_EN
  logic               exc_misalign;
`endif

  mem_access_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dmem ();

  mem_access_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .reg_write_e     (reg_write_e),
    .mem_to_reg_e    (mem_to_reg_e),
    .mem_read_e      (mem_read_e),
    .mem_write_e     (mem_write_e),
    .mem_size_e      (mem_size_e),
    .mem_unsigned_e  (mem_unsigned_e),
    .branch_e        (branch_e),
    .zero_e          (zero_e),
    .alu_out_e       (alu_out_e),
    .write_data_e    (write_data_e),
    .write_reg_e     (write_reg_e),
    .pc_branch_e     (pc_branch_e),
    .stall           (stall),
    .read_data_m     (read_data_m),
    .alu_out_m       (alu_out_m),
    .write_reg_m     (write_reg_m),
    .reg_write_m     (reg_write_m),
    .mem_to_reg_m    (mem_to_reg_m),
    .if_pc_src       (if_pc_src),
    .if_pc_branch_in (if_pc_branch_in),
`ifdef MEM_MISALIGN_TRAP_EN
    .exc_misalign    (exc_misalign),
`endif
    .dmem            (dmem)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_e();
    reg_write_e = 0; mem_to_reg_e = 0; mem_read_e = 0; mem_write_e = 0;
    mem_size_e = 2'b00; mem_unsigned_e = 0; branch_e = 0; zero_e = 0;
    alu_out_e = '0; write_data_e = '0; write_reg_e = '0; pc_branch_e = '0;
  endtask

  task automatic set_e(input logic rd, input logic wr, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    idle_e();
    mem_read_e = rd; mem_write_e = wr; mem_size_e = size; mem_unsigned_e = uns;
    alu_out_e = addr; write_data_e = wd;
    reg_write_e = rd; mem_to_reg_e = rd; write_reg_e = 5'd7;
  endtask

  task automatic expect_txn(input string tag, input logic [31:0] addr, input logic [3:0] be,
                            input logic we, input logic [31:0] wd, input logic [31:0] rd,
                            input logic [31:0] alu);
    exp_t e;
    e.tag = tag; e.addr = addr; e.be = be; e.we = we; e.wdata = wd;
    e.rdata = rd; e.rw = ~we; e.alu = alu;
    sb.push_back(e);
  endtask

  // Capture the driven access, hold ack low for 'delay' cycles, then ack.
  task automatic access(input int delay, input logic [31:0] rdata);
    exp_t e;
    @(posedge clk); #1;
    idle_e();
    dmem.dmem_ack = 1'b0;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("stall_wait", stall, 1);
      check("req_wait", dmem.dmem_req, 1);
      @(posedge clk); #1;
    end
    dmem.dmem_ack = 1'b1;
    dmem.dmem_rdata = rdata;
    @(negedge clk);
    check("sb_nonempty", (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, "_req"},   dmem.dmem_req, 1);
      check({e.tag, "_stall"}, stall, 0);
      check({e.tag, "_addr"},  dmem.dmem_addr, e.addr);
      check({e.tag, "_be"},    dmem.dmem_be, e.be);
      check({e.tag, "_we"},    dmem.dmem_we, e.we);
      if (e.we) check({e.tag, "_wdata"}, dmem.dmem_wdata, e.wdata);
      check({e.tag, "_rdata"}, read_data_m, e.rdata);
      check({e.tag, "_regwr"}, reg_write_m, e.rw);
      check({e.tag, "_m2r"},   mem_to_reg_m, e.rw);
      check({e.tag, "_wreg"},  write_reg_m, 5'd7);
      check({e.tag, "_alu"},   alu_out_m, e.alu);
      $display("txn %s addr=0x%08h be=%b we=%b wdata=0x%08h rdata=0x%08h",
               e.tag, dmem.dmem_addr, dmem.dmem_be, dmem.dmem_we, dmem.dmem_wdata, read_data_m);
    end
    @(posedge clk); #1;
    dmem.dmem_ack = 1'b0;
  endtask

  initial begin
    idle_e();
    dmem.dmem_ack = 1'b0;
    dmem.dmem_rdata = '0;
    #2;
    check("rst_stall", stall, 0);
    check("rst_req", dmem.dmem_req, 0);
    check("rst_we", dmem.dmem_we, 0);
    check("rst_be", dmem.dmem_be, 0);
    check("rst_rdata", read_data_m, 0);
    check("rst_alu", alu_out_m, 0);
    check("rst_wreg", write_reg_m, 0);
    check("rst_regwr", reg_write_m, 0);
    check("rst_m2r", mem_to_reg_m, 0);
    check("rst_pcsrc", if_pc_src, 0);
    check("rst_pcbr", if_pc_branch_in, 0);
    set_e(1, 0, 2'b10, 0, 32'h40, 0);
    branch_e = 1; zero_e = 1; pc_branch_e = 32'h88;
    @(posedge clk); #1;
    check("rst_hold_req", dmem.dmem_req, 0);
    check("rst_hold_pcsrc", if_pc_src, 0);
    @(negedge clk);
    idle_e();
    rst = 1'b1;

    set_e(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    expect_txn("st_w", 32'h10, 4'b1111, 1, 32'hDEADBEEF, 0, 32'h10);
    access(0, 32'h0);

    set_e(1, 0, 2'b00, 0, 32'h13, 0);
    expect_txn("ld_b", 32'h13, 4'b1000, 0, 0, 32'hFFFFFF80, 32'h13);
    access(3, 32'h80FFFFFF);

    set_e(1, 0, 2'b01, 1, 32'h22, 0);
    expect_txn("ld_hu", 32'h22, 4'b1100, 0, 0, 32'h00008001, 32'h22);
    access(1, 32'h8001_0000);

    set_e(1, 0, 2'b01, 0, 32'h22, 0);
    expect_txn("ld_h", 32'h22, 4'b1100, 0, 0, 32'hFFFF8001, 32'h22);
    access(0, 32'h8001_0000);

    set_e(0, 1, 2'b00, 0, 32'h11, 32'h000000AB);
    expect_txn("st_b", 32'h11, 4'b0010, 1, 32'hABABABAB, 0, 32'h11);
    access(0, 32'h0);

    set_e(0, 1, 2'b01, 0, 32'h12, 32'h00001234);
    expect_txn("st_h", 32'h12, 4'b1100, 1, 32'h12341234, 0, 32'h12);
    access(2, 32'h0);

    set_e(1, 0, 2'b11, 0, 32'h14, 0);
    expect_txn("ld_d32", 32'h14, 4'b1111, 0, 0, 32'h12345678, 32'h14);
    access(1, 32'h12345678);

    set_e(1, 0, 2'b00, 1, 32'h11, 0);
    expect_txn("ld_bu", 32'h11, 4'b0010, 0, 0, 32'h000000FF, 32'h11);
    access(0, 32'h0000FF00);

`ifdef MEM_MISALIGN_TRAP_EN
    set_e(1, 0, 2'b10, 0, 32'h21, 0);
    @(posedge clk); #1;
    idle_e();
    @(negedge clk);
    check("mis_exc", exc_misalign, 1);
    check("mis_req", dmem.dmem_req, 0);
    check("mis_stall", stall, 0);
    check("mis_regwr", reg_write_m, 0);
    $display("txn mis_w exc=%b req=%b", exc_misalign, dmem.dmem_req);
    @(posedge clk); #1;
    @(negedge clk);
    check("mis_exc_end", exc_misalign, 0);
`else
    set_e(1, 0, 2'b10, 0, 32'h21, 0);
    expect_txn("ld_w_mis", 32'h20, 4'b1111, 0, 0, 32'hCAFEF00D, 32'h21);
    access(1, 32'hCAFEF00D);
`endif

    branch_e = 1; zero_e = 1; pc_branch_e = 32'h400;
    @(posedge clk); #1;
    idle_e();
    @(negedge clk);
    check("br_src", if_pc_src, 2'b01);
    check("br_pc", if_pc_branch_in, 32'h400);
    $display("txn branch src=%b pc=0x%08h", if_pc_src, if_pc_branch_in);
    @(posedge clk); #1;
    @(negedge clk);
    check("br_src_end", if_pc_src, 2'b00);
    check("br_pc_end", if_pc_branch_in, 0);
    branch_e = 1; zero_e = 0; pc_branch_e = 32'h500;
    @(posedge clk); #1;
    idle_e();
    @(negedge clk);
    check("br_nt_src", if_pc_src, 2'b00);

    set_e(1, 0, 2'b10, 0, 32'h30, 0);
    @(posedge clk); #1;
    idle_e();
    dmem.dmem_ack = 1'b0;
    @(negedge clk);
    check("rw_stall", stall, 1);
    check("rw_req", dmem.dmem_req, 1);
    #2 rst = 1'b0;
    #1;
    check("rw_req_async", dmem.dmem_req, 0);
    check("rw_stall_async", stall, 0);
    check("rw_regwr_async", reg_write_m, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    dmem.dmem_ack = 1'b1;
    dmem.dmem_rdata = 32'h11111111;
    @(negedge clk);
    check("rw_late_req", dmem.dmem_req, 0);
    check("rw_late_stall", stall, 0);
    check("rw_late_rdata", read_data_m, 0);
    $display("txn reset_wait req=%b rdata=0x%08h", dmem.dmem_req, read_data_m);
    @(posedge clk); #1;
    dmem.dmem_ack = 1'b0;

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
